// File: rtl/imem_pkg.sv
// imem_pkg: constants and types shared by the instruction-memory fetch blocks.
//   NOP_INST      : instruction returned for any failed fetch (addi x0,x0,0)
//   RD/RS1/RS2_LSB: bit positions of the register fields in a 32-bit instruction
//   REG_W         : register field width
//   imem_rsp_t    : one fetch response {addr, inst, err}, the response FIFO entry
package imem_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam int          RD_LSB      = 7;
    localparam int          RS1_LSB     = 15;
    localparam int          RS2_LSB     = 20;
    localparam int          REG_W       = 5;
    localparam int          IMEM_ADDR_W = 32;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [31:0]            inst;
        logic                   err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: synchronous in-order FIFO of imem_rsp_t.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the FIFO at the next edge (wins over push/pop)
//   push/push_data : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (meaningful only when !empty)
//   count/empty: occupancy
// A push and a pop in the same cycle are both honoured.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  imem_rsp_t                push_data,
    input  logic                     pop,
    output imem_rsp_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    imem_rsp_t        storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && !empty;
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/imem_stream.sv
// imem_stream: instruction memory with a registered read and valid/ready
// fetch request/response streams.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr : fetch request (byte address)
//   rsp_valid/rsp_ready      : fetch response handshake
//   rsp_addr/rsp_inst/rsp_err: response payload (err => misaligned, out of
//                              range or parity failure; inst is then NOP)
//   rsp_rsw/rsp_rs1/rsp_rs2  : rd/rs1/rs2 fields of rsp_inst
//   rsp_perr                 : parity failure (only with IMEM_STREAM_PARITY_EN)
//   flush                    : drop the in-flight read and all buffered responses
//   ld_en/ld_addr/ld_data    : word load port (ld_addr[1:0] ignored)
// Optional feature macro: IMEM_STREAM_PARITY_EN (per-word even parity).
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable while valid && !ready.
module imem_stream
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int RSP_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [31:0]       rsp_inst,
    output logic [4:0]        rsp_rsw,
    output logic [4:0]        rsp_rs1,
    output logic [4:0]        rsp_rs2,
    output logic              rsp_err,
`ifdef IMEM_STREAM_PARITY_EN
    output logic              rsp_perr,
`endif
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam int              IDX_W = $clog2(DEPTH_WORDS);
    localparam int              CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * 4);

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
    endfunction

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       rd_word;
    logic              inflight;
    logic [ADDR_W-1:0] if_addr;
    logic              if_bad;
    logic              if_err;
    imem_rsp_t         if_ent;
    imem_rsp_t         fifo_head;
    imem_rsp_t         out;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occ;
    logic              fifo_empty;
    logic              accept;
    logic              pop_any;
    logic              fifo_push;
    logic              fifo_pop;
    logic              ld_ok;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  req_idx;

    assign ld_idx  = ld_addr[IDX_W+1:2];
    assign req_idx = req_addr[IDX_W+1:2];
    assign ld_ok   = ld_en && ({1'b0, ld_addr} < LIMIT);

    // Occupancy counts the in-flight read so the FIFO can always absorb it.
    assign occ       = fifo_count + CNT_W'(inflight);
    assign req_ready = !rst && !flush && (occ < CNT_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    // Loads and reads live in separate processes so a same-word load and
    // read in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word <= mem[req_idx];
        end
    end

`ifdef IMEM_STREAM_PARITY_EN
    logic mem_par [DEPTH_WORDS];
    logic rd_par;

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem_par[ld_idx] <= ^ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_par <= mem_par[req_idx];
        end
    end

    assign if_err = if_bad || ((^rd_word) != rd_par);
`else
    assign if_err = if_bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            if_addr  <= '0;
            if_bad   <= 1'b0;
        end else begin
            inflight <= accept && !flush;
            if (accept) begin
                if_addr <= req_addr;
                if_bad  <= addr_bad(req_addr);
            end
        end
    end

    always_comb begin
        if_ent      = '0;
        if_ent.addr = IMEM_ADDR_W'(if_addr);
        if_ent.inst = if_err ? NOP_INST : rd_word;
        if_ent.err  = if_err;
    end

    // The in-flight read is visible one cycle after acceptance. When the FIFO
    // is empty it is presented directly and, if popped, never enters the FIFO;
    // otherwise it is queued behind older entries.
    assign rsp_valid = inflight || !fifo_empty;
    assign pop_any   = rsp_valid && rsp_ready && !flush;
    assign fifo_pop  = pop_any && !fifo_empty;
    assign fifo_push = inflight && !(pop_any && fifo_empty);

    imem_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (if_ent),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Outputs read zero while no response is available.
    always_comb begin
        out = '0;
        if (rsp_valid) begin
            out = fifo_empty ? if_ent : fifo_head;
        end
    end

    assign rsp_addr = out.addr[ADDR_W-1:0];
    assign rsp_inst = out.inst;
    assign rsp_err  = out.err;
    assign rsp_rsw  = out.inst[RD_LSB +: REG_W];
    assign rsp_rs1  = out.inst[RS1_LSB +: REG_W];
    assign rsp_rs2  = out.inst[RS2_LSB +: REG_W];

`ifdef IMEM_STREAM_PARITY_EN
    // A flagged response at a good address can only be a parity failure.
    assign rsp_perr = out.err && !addr_bad(rsp_addr);
`endif

endmodule
